// File: rtl/isp_frame_counter.sv
// isp_frame_counter
//
// Counts completed video frames from the ISP timing signals and latches the
// href count of every closed frame for debug. A frame is counted only when
// its line count lies within [MIN_LINES, MAX_LINES]. A frame left open for
// TIMEOUT_CYC cycles with no vsync edge is abandoned and flagged as bad.
//
// Optional build macro: ISP_FRAME_SYNC_EN adds an extra input register stage
// (d0) ahead of d1 on vsync/href for an asynchronous timing source. This
// increases the vsync-to-output latency by one cycle.
//
// Ports:
//   ispclk        in   sole clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   vsync_in      in   frame sync, rising edge marks a frame boundary
//   href_in       in   line valid, rising edge marks one line
//   enable        in   counting enable; low discards the open frame silently
//   clr           in   synchronous clear, overrides all edges in its cycle
//   framesCnt     out  count of valid frames, wraps modulo 2^16
//   frame_start   out  one-cycle pulse per accepted vsync rise
//   frame_done    out  one-cycle pulse per counted frame
//   bad_frame     out  one-cycle pulse per rejected or timed-out frame
//   line_cnt_last out  href count of the most recently closed frame
//
// State table:
//   IDLE    | counting disabled
//   WAIT_VS | enabled, no frame open, waiting for a vsync rise
//   ACTIVE  | frame open, counting hrefs and timing out
module isp_frame_counter #(
    parameter logic [11:0] MIN_LINES   = 12'd16,
    parameter logic [11:0] MAX_LINES   = 12'd2047,
    parameter logic [31:0] TIMEOUT_CYC = 32'd192000000
) (
    input  logic        ispclk,
    input  logic        rst_n,
    input  logic        vsync_in,
    input  logic        href_in,
    input  logic        enable,
    input  logic        clr,
    output logic [15:0] framesCnt,
    output logic        frame_start,
    output logic        frame_done,
    output logic        bad_frame,
    output logic [11:0] line_cnt_last
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    // The timeout runs as a down-counter loaded with TIMEOUT_CYC-1, so that
    // reaching zero is the same cycle as an up-count reaching TIMEOUT_CYC-1.
    localparam logic [31:0] TMO_LOAD = TIMEOUT_CYC - 32'd1;

    logic vs_src, hr_src;
    logic vs_d1, vs_d2, hr_d1, hr_d2;
    logic vs_rise, hr_rise;

`ifdef ISP_FRAME_SYNC_EN
    logic vs_d0, hr_d0;

    always_ff @(posedge ispclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d0 <= 1'b0;
            hr_d0 <= 1'b0;
        end else begin
            vs_d0 <= vsync_in;
            hr_d0 <= href_in;
        end
    end

    assign vs_src = vs_d0;
    assign hr_src = hr_d0;
`else
    assign vs_src = vsync_in;
    assign hr_src = href_in;
`endif

    always_ff @(posedge ispclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d1 <= 1'b0;
            vs_d2 <= 1'b0;
            hr_d1 <= 1'b0;
            hr_d2 <= 1'b0;
        end else begin
            vs_d1 <= vs_src;
            vs_d2 <= vs_d1;
            hr_d1 <= hr_src;
            hr_d2 <= hr_d1;
        end
    end

    assign vs_rise = vs_d1 & ~vs_d2;
    assign hr_rise = hr_d1 & ~hr_d2;

    state_t      state, state_nxt;
    logic [11:0] line_cnt, line_nxt, line_inc, last_nxt;
    logic [31:0] tmo_cnt, tmo_nxt;
    logic [15:0] frames_q, frames_nxt;
    logic        start_nxt, done_nxt, bad_nxt;
    logic        frame_ok;

    // Line count including an href rise in this cycle, so a coincident href
    // lands in the frame that is closing.
    assign line_inc = (hr_rise && (line_cnt != 12'hFFF)) ? line_cnt + 12'd1 : line_cnt;
    assign frame_ok = (line_inc >= MIN_LINES) && (line_inc <= MAX_LINES);

    always_comb begin
        state_nxt  = state;
        line_nxt   = line_cnt;
        tmo_nxt    = tmo_cnt;
        frames_nxt = frames_q;
        last_nxt   = line_cnt_last;
        start_nxt  = 1'b0;
        done_nxt   = 1'b0;
        bad_nxt    = 1'b0;

        if (clr) begin
            state_nxt  = enable ? WAIT_VS : IDLE;
            line_nxt   = 12'd0;
            tmo_nxt    = TMO_LOAD;
            frames_nxt = 16'd0;
            last_nxt   = 12'd0;
        end else if (!enable) begin
            state_nxt = IDLE;
            line_nxt  = 12'd0;
            tmo_nxt   = TMO_LOAD;
        end else begin
            case (state)
                IDLE: state_nxt = WAIT_VS;
                WAIT_VS: begin
                    if (vs_rise) begin
                        start_nxt = 1'b1;
                        line_nxt  = 12'd0;
                        tmo_nxt   = TMO_LOAD;
                        state_nxt = ACTIVE;
                    end
                end
                ACTIVE: begin
                    line_nxt = line_inc;
                    tmo_nxt  = tmo_cnt - 32'd1;
                    if (vs_rise) begin
                        // Close the frame and open the next one in one cycle.
                        last_nxt  = line_inc;
                        start_nxt = 1'b1;
                        line_nxt  = 12'd0;
                        tmo_nxt   = TMO_LOAD;
                        if (frame_ok) begin
                            frames_nxt = frames_q + 16'd1;
                            done_nxt   = 1'b1;
                        end else begin
                            bad_nxt = 1'b1;
                        end
                    end else if (tmo_cnt == 32'd0) begin
                        last_nxt  = line_inc;
                        bad_nxt   = 1'b1;
                        line_nxt  = 12'd0;
                        tmo_nxt   = TMO_LOAD;
                        state_nxt = WAIT_VS;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge ispclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            line_cnt      <= 12'd0;
            tmo_cnt       <= TMO_LOAD;
            frames_q      <= 16'd0;
            line_cnt_last <= 12'd0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
            bad_frame     <= 1'b0;
        end else begin
            state         <= state_nxt;
            line_cnt      <= line_nxt;
            tmo_cnt       <= tmo_nxt;
            frames_q      <= frames_nxt;
            line_cnt_last <= last_nxt;
            frame_start   <= start_nxt;
            frame_done    <= done_nxt;
            bad_frame     <= bad_nxt;
        end
    end

    assign framesCnt = frames_q;

endmodule

// File: tb/tb_isp_frame_counter.sv
module tb_isp_frame_counter;

    localparam int TMO = 10000;
`ifdef ISP_FRAME_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        ispclk = 1'b0;
    logic        rst_n;
    logic        vsync_in, href_in, enable, clr;
    logic [15:0] framesCnt;
    logic        frame_start, frame_done, bad_frame;
    logic [11:0] line_cnt_last;

    isp_frame_counter #(
        .MIN_LINES  (12'd16),
        .MAX_LINES  (12'd2047),
        .TIMEOUT_CYC(32'd10000)
    ) dut (
        .ispclk       (ispclk),
        .rst_n        (rst_n),
        .vsync_in     (vsync_in),
        .href_in      (href_in),
        .enable       (enable),
        .clr          (clr),
        .framesCnt    (framesCnt),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .bad_frame    (bad_frame),
        .line_cnt_last(line_cnt_last)
    );

    always #5 ispclk = ~ispclk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // observed pulse counts and cycle stamps
    int n_start = 0, n_done = 0, n_bad = 0;
    int t_start = 0, t_bad = 0;

    // reference model of what the outputs should be
    logic [15:0] m_frames = 16'd0;
    logic [11:0] m_last = 12'd0;
    int m_start = 0, m_done = 0, m_bad = 0;

    always @(posedge ispclk) cyc++;

    always @(negedge ispclk) begin
        if (frame_start) begin n_start++; t_start = cyc; end
        if (frame_done) n_done++;
        if (bad_frame) begin n_bad++; t_bad = cyc; end
    end

    // A vsync rise while a frame is open: close it with n hrefs, open the next.
    function automatic void close_frame(input int n);
        int c;
        c = (n > 4095) ? 4095 : n;
        m_last = c[11:0];
        m_start++;
        if (c >= 16 && c <= 2047) begin
            m_frames = m_frames + 16'd1;
            m_done++;
        end else begin
            m_bad++;
        end
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge ispclk);
    endtask

    task automatic pulse_href(input int gap);
        href_in = 1'b1;
        wait_cyc(1);
        href_in = 1'b0;
        wait_cyc(1 + gap);
    endtask

    task automatic pulse_vsync();
        vsync_in = 1'b1;
        wait_cyc(1);
        vsync_in = 1'b0;
        wait_cyc(4);
    endtask

    task automatic send_hrefs(input int n, input int max_gap);
        for (int i = 0; i < n; i++) pulse_href(max_gap == 0 ? 0 : int'($urandom_range(0, max_gap)));
    endtask

    task automatic send_frame(input int n, input int max_gap);
        send_hrefs(n, max_gap);
        pulse_vsync();
        close_frame(n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vsync_in = 1'b0; href_in = 1'b0; enable = 1'b0; clr = 1'b0;
        wait_cyc(3);
        n_cmp++; if (framesCnt !== 16'd0) begin n_err++; $display("FAIL reset_frames got %h exp 0000", framesCnt); end
        n_cmp++; if (line_cnt_last !== 12'd0) begin n_err++; $display("FAIL reset_last got %h exp 000", line_cnt_last); end
        n_cmp++; if ({frame_start, frame_done, bad_frame} !== 3'b000) begin n_err++; $display("FAIL reset_pulses got %b exp 000", {frame_start, frame_done, bad_frame}); end
        rst_n = 1'b1;
        wait_cyc(2);
        n_cmp++; if ({frame_start, frame_done, bad_frame} !== 3'b000) begin n_err++; $display("FAIL idle_pulses got %b exp 000", {frame_start, frame_done, bad_frame}); end
    endtask

    task automatic test_basic();
        enable = 1'b1;
        wait_cyc(3);
        pulse_vsync();
        m_start++;
        for (int f = 0; f < 3; f++) send_frame(100, 1);
        n_cmp++; if (framesCnt !== m_frames) begin n_err++; $display("FAIL basic_frames got %h exp %h", framesCnt, m_frames); end
        n_cmp++; if (line_cnt_last !== 12'd100) begin n_err++; $display("FAIL basic_last got %0d exp 100", line_cnt_last); end
        n_cmp++; if (n_done !== 3) begin n_err++; $display("FAIL basic_done got %0d exp 3", n_done); end
        n_cmp++; if (n_bad !== 0) begin n_err++; $display("FAIL basic_bad got %0d exp 0", n_bad); end
        n_cmp++; if (n_start !== 4) begin n_err++; $display("FAIL basic_start got %0d exp 4", n_start); end
    endtask

    task automatic test_short();
        send_frame(5, 0);
        n_cmp++; if (framesCnt !== m_frames) begin n_err++; $display("FAIL short_frames got %h exp %h", framesCnt, m_frames); end
        n_cmp++; if (line_cnt_last !== 12'd5) begin n_err++; $display("FAIL short_last got %0d exp 5", line_cnt_last); end
        n_cmp++; if (n_bad !== m_bad) begin n_err++; $display("FAIL short_bad got %0d exp %0d", n_bad, m_bad); end
    endtask

    task automatic test_bounds();
        int sizes[6] = '{15, 16, 2047, 2048, 0, 4100};
        foreach (sizes[k]) begin
            send_frame(sizes[k], 0);
            n_cmp++; if (framesCnt !== m_frames) begin n_err++; $display("FAIL bounds_frames n=%0d got %h exp %h", sizes[k], framesCnt, m_frames); end
            n_cmp++; if (line_cnt_last !== m_last) begin n_err++; $display("FAIL bounds_last n=%0d got %0d exp %0d", sizes[k], line_cnt_last, m_last); end
            n_cmp++; if (n_done !== m_done || n_bad !== m_bad) begin n_err++; $display("FAIL bounds_pulses n=%0d got done %0d bad %0d exp done %0d bad %0d", sizes[k], n_done, n_bad, m_done, m_bad); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            int n;
            n = int'($urandom_range(0, 40));
            send_frame(n, 2);
            n_cmp++; if (framesCnt !== m_frames || line_cnt_last !== m_last) begin n_err++; $display("FAIL random n=%0d got frames %h last %0d exp frames %h last %0d", n, framesCnt, line_cnt_last, m_frames, m_last); end
        end
        n_cmp++; if (n_start !== m_start || n_done !== m_done || n_bad !== m_bad) begin n_err++; $display("FAIL random_pulses got %0d/%0d/%0d exp %0d/%0d/%0d", n_start, n_done, n_bad, m_start, m_done, m_bad); end
    endtask

    task automatic test_latency();
        int c0, lat;
        send_hrefs(20, 0);
        lat = -1;
        c0 = cyc;
        vsync_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge ispclk);
            if (i == 1) vsync_in = 1'b0;
            if (frame_done) begin lat = cyc - c0; break; end
        end
        close_frame(20);
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL latency got %0d exp %0d", lat, LAT); end
        n_cmp++; if (frame_start !== 1'b1 || framesCnt !== m_frames) begin n_err++; $display("FAIL latency_outputs got start %b frames %h exp 1 %h", frame_start, framesCnt, m_frames); end
        wait_cyc(1);
        n_cmp++; if (frame_done !== 1'b0 || frame_start !== 1'b0) begin n_err++; $display("FAIL pulse_width got done %b start %b exp 0 0", frame_done, frame_start); end
        wait_cyc(3);
    endtask

    task automatic test_timeout();
        int b0, s0;
        send_frame(17, 0);
        send_hrefs(20, 0);
        b0 = n_bad;
        for (int i = 0; i < TMO + 200 && n_bad == b0; i++) @(negedge ispclk);
        m_bad++;
        m_last = 12'd20;
        n_cmp++; if (n_bad !== m_bad) begin n_err++; $display("FAIL timeout_bad got %0d exp %0d", n_bad, m_bad); end
        n_cmp++; if (t_bad - t_start !== TMO) begin n_err++; $display("FAIL timeout_cycles got %0d exp %0d", t_bad - t_start, TMO); end
        n_cmp++; if (line_cnt_last !== 12'd20 || framesCnt !== m_frames) begin n_err++; $display("FAIL timeout_latch got last %0d frames %h exp 20 %h", line_cnt_last, framesCnt, m_frames); end
        s0 = n_start;
        pulse_vsync();
        m_start++;
        n_cmp++; if (n_start !== s0 + 1 || n_done !== m_done || n_bad !== m_bad) begin n_err++; $display("FAIL timeout_reopen got %0d/%0d/%0d exp %0d/%0d/%0d", n_start, n_done, n_bad, s0 + 1, m_done, m_bad); end
        n_cmp++; if (line_cnt_last !== 12'd20) begin n_err++; $display("FAIL timeout_reopen_last got %0d exp 20", line_cnt_last); end
    endtask

    task automatic test_clr();
        send_hrefs(20, 0);
        vsync_in = 1'b1;
        wait_cyc(1);
        vsync_in = 1'b0;
        wait_cyc(LAT - 2);
        clr = 1'b1;
        wait_cyc(1);
        clr = 1'b0;
        wait_cyc(4);
        m_frames = 16'd0;
        m_last = 12'd0;
        n_cmp++; if (framesCnt !== 16'd0 || line_cnt_last !== 12'd0) begin n_err++; $display("FAIL clr_values got frames %h last %0d exp 0000 0", framesCnt, line_cnt_last); end
        n_cmp++; if (n_start !== m_start || n_done !== m_done || n_bad !== m_bad) begin n_err++; $display("FAIL clr_pulses got %0d/%0d/%0d exp %0d/%0d/%0d", n_start, n_done, n_bad, m_start, m_done, m_bad); end
        // WAIT_VS: hrefs are ignored, the next vsync only opens a frame
        send_hrefs(20, 0);
        pulse_vsync();
        m_start++;
        n_cmp++; if (n_start !== m_start || n_done !== m_done || framesCnt !== 16'd0) begin n_err++; $display("FAIL clr_waitvs got start %0d done %0d frames %h exp %0d %0d 0000", n_start, n_done, framesCnt, m_start, m_done); end
    endtask

    task automatic test_enable_drop();
        send_frame(18, 0);
        send_hrefs(20, 0);
        enable = 1'b0;
        wait_cyc(4);
        n_cmp++; if (n_bad !== m_bad || framesCnt !== m_frames || line_cnt_last !== 12'd18) begin n_err++; $display("FAIL endrop_hold got bad %0d frames %h last %0d exp %0d %h 18", n_bad, framesCnt, line_cnt_last, m_bad, m_frames); end
        enable = 1'b1;
        wait_cyc(2);
        pulse_vsync();
        m_start++;
        n_cmp++; if (n_start !== m_start || n_done !== m_done || n_bad !== m_bad) begin n_err++; $display("FAIL endrop_reopen got %0d/%0d/%0d exp %0d/%0d/%0d", n_start, n_done, n_bad, m_start, m_done, m_bad); end
        send_frame(30, 1);
        n_cmp++; if (framesCnt !== m_frames || line_cnt_last !== 12'd30) begin n_err++; $display("FAIL endrop_next got frames %h last %0d exp %h 30", framesCnt, line_cnt_last, m_frames); end
    endtask

    task automatic test_wrap();
        force dut.frames_q = 16'hFFFE;
        wait_cyc(1);
        release dut.frames_q;
        wait_cyc(1);
        m_frames = 16'hFFFE;
        n_cmp++; if (framesCnt !== 16'hFFFE) begin n_err++; $display("FAIL wrap_preload got %h exp fffe", framesCnt); end
        send_frame(16, 0);
        n_cmp++; if (framesCnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ffff got %h exp ffff", framesCnt); end
        send_frame(16, 0);
        n_cmp++; if (framesCnt !== 16'h0000 || n_done !== m_done) begin n_err++; $display("FAIL wrap_zero got %h done %0d exp 0000 %0d", framesCnt, n_done, m_done); end
    endtask

    task automatic test_async_reset();
        send_frame(20, 0);
        send_hrefs(10, 0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (framesCnt !== 16'd0 || line_cnt_last !== 12'd0) begin n_err++; $display("FAIL async_reset got frames %h last %0d exp 0000 0", framesCnt, line_cnt_last); end
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_bounds();
        test_random();
        test_latency();
        test_timeout();
        test_clr();
        test_enable_drop();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
